sram_d_arbiter: RTL and testbench
=================================

Name: sram_d_arbiter

Overview:
- Two-master OBI arbiter that sits directly upstream of the SRAM wrapper's data port and drives that port's muxed request.
- Master 0 is the core LSU; master 1 is the DMA/debug data master.
- Performs round-robin arbitration and an address-range check, and routes each 1-cycle-latency response back to the master that issued it.
- Out-of-range accesses are absorbed locally and answered with an error response; they are never forwarded.

Parameters:
SRAM_BASE_ADDR, 32'h8000_0000, first legal byte address (inclusive)
SRAM_END_ADDR, 32'h8000_C000, end of legal range (exclusive)
ERR_RDATA, 32'hDEAD_BEEF, rdata returned on error responses
ERR_CNT_W, 8, width of saturating illegal-access counter

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
m0_req_i  input  1  master 0 OBI request
m0_gnt_o  output  1  master 0 grant
m0_addr_i  input  32  master 0 byte address
m0_we_i  input  1  master 0 write enable
m0_be_i  input  4  master 0 byte enables
m0_wdata_i  input  32  master 0 write data
m0_rvalid_o  output  1  master 0 response valid
m0_rdata_o  output  32  master 0 read data
m0_err_o  output  1  master 0 response error
m1_* (req_i, gnt_o, addr_i, we_i, be_i, wdata_i, rvalid_o, rdata_o, err_o)  same widths and meanings for master 1
sram_d_req_o  output  1  request to SRAM wrapper data port
sram_d_gnt_i  input  1  grant from SRAM wrapper
sram_d_addr_o  output  32  forwarded address
sram_d_we_o  output  1  forwarded write enable
sram_d_be_o  output  4  forwarded byte enables
sram_d_wdata_o  output  32  forwarded write data
sram_d_rvalid_i  input  1  SRAM response valid, exactly 1 cycle after grant
sram_d_rdata_i  input  32  SRAM read data
illegal_access_o  output  1  1-cycle pulse in the grant cycle of an illegal access
err_addr_o  output  32  address of most recent illegal access
err_cnt_o  output  ERR_CNT_W  count of illegal accesses, saturating

Behaviour:
- Legality: legal iff SRAM_BASE_ADDR <= addr < SRAM_END_ADDR and addr[1:0]==0. Compare unsigned.
- Arbitration is combinational each cycle:
  - Only one master requesting: that master is selected.
  - Both requesting: select the master not held in last_grant.
  - last_grant (reg) updates to the selected master on every granted cycle; reset value 1, so master 0 wins the first tie.
- Legal selected request:
  - sram_d_req_o=1 and the selected master's addr/we/be/wdata are driven onto sram_d_*.
  - The selected master's gnt_o = sram_d_gnt_i.
- Illegal selected request:
  - sram_d_req_o=0; the selected master's gnt_o=1 in the same cycle.
  - illegal_access_o=1 that cycle.
  - err_addr_o <= addr and err_cnt_o <= err_cnt_o+1 (holds at all-ones) at the clock edge.
- Non-selected master: gnt_o=0. OBI requires it to hold req and fields stable, so it is served next cycle.
- When no master requests, sram_d_* outputs are 0.
- Response tracking: on each granted cycle register resp_pend=1, resp_owner=selected master, resp_err=illegal; otherwise resp_pend<=0.
- Response delivery, one cycle after grant, to resp_owner only:
  - resp_err=0: owner rvalid_o = sram_d_rvalid_i, rdata_o = sram_d_rdata_i, err_o = 0.
  - resp_err=1: owner rvalid_o=1, rdata_o=ERR_RDATA, err_o=1.
  - Non-owner: rvalid_o=0, rdata_o=0, err_o=0.
- Back-to-back grants every cycle are supported. A response and a new grant in the same cycle are independent.
- sram_d_rvalid_i with resp_pend=0 is ignored and not routed.
- Writes produce an rvalid as well; rdata is don't-care on legal writes.
- Reset, applied at any time:
  - last_grant=1, resp_pend=0, err_addr_o=0, err_cnt_o=0.
  - While rst_i=1, all gnt/rvalid/err outputs and sram_d_req_o are 0.
  - A response pending when reset asserts is dropped and never delivered.

Test Plan:
- M0 read at 32'h8000_0010, M1 idle → cycle 0: sram_d_req_o=1, addr 32'h8000_0010, m0_gnt_o=1. Cycle 1: m0_rvalid_o=1, m0_rdata_o=sram_d_rdata_i, m1_rvalid_o=0.
- M0 and M1 both request continuously from reset → grants alternate M0,M1,M0,M1. Each rvalid reaches the correct owner one cycle later with that owner's data.
- M1 write at 32'h8000_C000 (end, exclusive) → sram_d_req_o=0, m1_gnt_o=1, illegal_access_o pulse. Next cycle: m1_err_o=1, m1_rdata_o=32'hDEAD_BEEF. err_addr_o=32'h8000_C000, err_cnt_o=1.
- Misaligned 32'h8000_0002 and below-base 32'h7FFF_FFFC each flagged illegal. 256 illegal accesses → err_cnt_o saturates at 8'hFF.
- M0 granted, rst_i asserted next cycle → no m0_rvalid_o delivered. After reset, a tie grants M0 first. err_cnt_o=0.
- sram_d_rvalid_i asserted with no pending request → no master rvalid asserted.

Source files
------------

// File: rtl/sram_d_arbiter.sv
// rtl/sram_d_arbiter.sv - two-master OBI arbiter with range check in front of the SRAM data port
//
// Round-robin arbitration between master 0 (core LSU) and master 1 (DMA/debug).
// Legal requests are forwarded to the SRAM wrapper data port. Illegal requests
// (out of range or misaligned) are granted locally and answered with an error.
// Each 1-cycle-latency response is routed back to the master that was granted.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   m0_* / m1_*                       OBI slave ports for master 0 / master 1
//   sram_d_*                          OBI master port toward the SRAM wrapper
//   illegal_access_o                  pulse in the grant cycle of an illegal access
//   err_addr_o, err_cnt_o             last illegal address, saturating illegal count
module sram_d_arbiter #(
  parameter logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SRAM_END_ADDR  = 32'h8000_C000,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 m0_req_i,
  output logic                 m0_gnt_o,
  input  logic [31:0]          m0_addr_i,
  input  logic                 m0_we_i,
  input  logic [3:0]           m0_be_i,
  input  logic [31:0]          m0_wdata_i,
  output logic                 m0_rvalid_o,
  output logic [31:0]          m0_rdata_o,
  output logic                 m0_err_o,
  input  logic                 m1_req_i,
  output logic                 m1_gnt_o,
  input  logic [31:0]          m1_addr_i,
  input  logic                 m1_we_i,
  input  logic [3:0]           m1_be_i,
  input  logic [31:0]          m1_wdata_i,
  output logic                 m1_rvalid_o,
  output logic [31:0]          m1_rdata_o,
  output logic                 m1_err_o,
  output logic                 sram_d_req_o,
  input  logic                 sram_d_gnt_i,
  output logic [31:0]          sram_d_addr_o,
  output logic                 sram_d_we_o,
  output logic [3:0]           sram_d_be_o,
  output logic [31:0]          sram_d_wdata_o,
  input  logic                 sram_d_rvalid_i,
  input  logic [31:0]          sram_d_rdata_i,
  output logic                 illegal_access_o,
  output logic [31:0]          err_addr_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  logic        sel;         // selected master: 0 = m0, 1 = m1
  logic        any_req;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_wdata;
  logic        sel_legal;
  logic        fwd;
  logic        granted;

  logic        last_grant;
  logic        resp_pend;
  logic        resp_owner;
  logic        resp_err;

  logic        deliver;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  // On a tie the master that did not win last time goes; otherwise the lone
  // requester (m1_req_i alone gives 1, m0_req_i alone or nobody gives 0).
  always_comb begin
    if (m0_req_i && m1_req_i) sel = ~last_grant;
    else                      sel = m1_req_i;
  end

  assign any_req   = (m0_req_i | m1_req_i) & ~rst_i;
  assign sel_addr  = sel ? m1_addr_i  : m0_addr_i;
  assign sel_we    = sel ? m1_we_i    : m0_we_i;
  assign sel_be    = sel ? m1_be_i    : m0_be_i;
  assign sel_wdata = sel ? m1_wdata_i : m0_wdata_i;

  assign sel_legal = (sel_addr >= SRAM_BASE_ADDR) && (sel_addr < SRAM_END_ADDR) &&
                     (sel_addr[1:0] == 2'b00);

  assign fwd              = any_req & sel_legal;
  assign illegal_access_o = any_req & ~sel_legal;
  // Illegal requests never reach the SRAM, so they are granted immediately here.
  assign granted          = fwd ? sram_d_gnt_i : illegal_access_o;

  assign sram_d_req_o   = fwd;
  assign sram_d_addr_o  = fwd ? sel_addr  : '0;
  assign sram_d_we_o    = fwd ? sel_we    : 1'b0;
  assign sram_d_be_o    = fwd ? sel_be    : '0;
  assign sram_d_wdata_o = fwd ? sel_wdata : '0;

  assign m0_gnt_o = granted & ~sel;
  assign m1_gnt_o = granted &  sel;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= 1'b1;
      resp_pend  <= 1'b0;
      resp_owner <= 1'b0;
      resp_err   <= 1'b0;
      err_addr_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      resp_pend <= granted;
      if (granted) begin
        last_grant <= sel;
        resp_owner <= sel;
        resp_err   <= ~sel_legal;
      end
      if (illegal_access_o) begin
        err_addr_o <= sel_addr;
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
      end
    end
  end

  // A response pending across a reset edge is suppressed while rst_i is high
  // and then cleared, so it is never delivered.
  assign deliver   = resp_pend & ~rst_i;
  assign rsp_valid = resp_err ? 1'b1      : sram_d_rvalid_i;
  assign rsp_data  = resp_err ? ERR_RDATA : sram_d_rdata_i;

  assign m0_rvalid_o = deliver & ~resp_owner & rsp_valid;
  assign m0_rdata_o  = (deliver & ~resp_owner) ? rsp_data : '0;
  assign m0_err_o    = deliver & ~resp_owner & resp_err;
  assign m1_rvalid_o = deliver &  resp_owner & rsp_valid;
  assign m1_rdata_o  = (deliver &  resp_owner) ? rsp_data : '0;
  assign m1_err_o    = deliver &  resp_owner & resp_err;

endmodule

// File: tb/tb_sram_d_arbiter.sv
// tb/tb_sram_d_arbiter.sv - self-checking bench for sram_d_arbiter
module tb_sram_d_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_req_i = 0, m1_req_i = 0;
  logic        m0_gnt_o, m1_gnt_o;
  logic [31:0] m0_addr_i = 0, m1_addr_i = 0;
  logic        m0_we_i = 0, m1_we_i = 0;
  logic [3:0]  m0_be_i = 0, m1_be_i = 0;
  logic [31:0] m0_wdata_i = 0, m1_wdata_i = 0;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_err_o, m1_err_o;
  logic        sram_d_req_o;
  logic        sram_d_gnt_i = 0;
  logic [31:0] sram_d_addr_o;
  logic        sram_d_we_o;
  logic [3:0]  sram_d_be_o;
  logic [31:0] sram_d_wdata_o;
  logic        sram_d_rvalid_i = 0;
  logic [31:0] sram_d_rdata_i = 0;
  logic        illegal_access_o;
  logic [31:0] err_addr_o;
  logic [7:0]  err_cnt_o;

  int checks = 0;
  int errors = 0;

  sram_d_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .sram_d_req_o(sram_d_req_o), .sram_d_gnt_i(sram_d_gnt_i), .sram_d_addr_o(sram_d_addr_o),
    .sram_d_we_o(sram_d_we_o), .sram_d_be_o(sram_d_be_o), .sram_d_wdata_o(sram_d_wdata_o),
    .sram_d_rvalid_i(sram_d_rvalid_i), .sram_d_rdata_i(sram_d_rdata_i),
    .illegal_access_o(illegal_access_o), .err_addr_o(err_addr_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state: who won last, the outstanding response, error log.
  int          m_last  = 1;
  bit          m_pend  = 0;
  int          m_owner = 0;
  bit          m_perr  = 0;
  logic [31:0] m_eaddr = 0;
  int          m_ecnt  = 0;
  bit          hs_prev = 0;

  // Expectations for the current cycle.
  int          e_w;
  bit          e_any, e_leg, e_sreq, e_ill, e_taken, e_gnt0, e_gnt1;
  logic [31:0] e_addr, e_wdata;
  bit          e_we;
  logic [3:0]  e_be;
  bit          e_rv0, e_rv1, e_er0, e_er1;
  logic [31:0] e_rd0, e_rd1;

  function automatic bit is_legal(logic [31:0] a);
    return (a >= 32'h8000_0000) && (a < 32'h8000_C000) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 6))
      0:       return 32'h8000_C000;
      1:       return 32'h8000_0000 + 32'($urandom_range(0, 32'h2FFF) * 4) + 32'($urandom_range(1, 3));
      2:       return 32'h7FFF_FFFC;
      3:       return $urandom;
      4:       return 32'h8000_BFFC;
      default: return 32'h8000_0000 + 32'($urandom_range(0, 32'h2FFF) * 4);
    endcase
  endfunction

  task automatic model_eval();
    bit r0, r1;
    r0 = m0_req_i;
    r1 = m1_req_i;
    if (r0 && r1) e_w = (m_last == 0) ? 1 : 0;
    else          e_w = r1 ? 1 : 0;
    e_any   = (r0 || r1) && !rst_i;
    e_addr  = (e_w == 1) ? m1_addr_i  : m0_addr_i;
    e_we    = (e_w == 1) ? m1_we_i    : m0_we_i;
    e_be    = (e_w == 1) ? m1_be_i    : m0_be_i;
    e_wdata = (e_w == 1) ? m1_wdata_i : m0_wdata_i;
    e_leg   = is_legal(e_addr);
    e_sreq  = e_any && e_leg;
    e_ill   = e_any && !e_leg;
    e_taken = e_any && (!e_leg || sram_d_gnt_i);
    e_gnt0  = e_taken && (e_w == 0);
    e_gnt1  = e_taken && (e_w == 1);
    e_rv0 = 0; e_rv1 = 0; e_er0 = 0; e_er1 = 0; e_rd0 = 0; e_rd1 = 0;
    if (m_pend && !rst_i) begin
      if (m_owner == 0) begin
        e_rv0 = m_perr ? 1'b1 : sram_d_rvalid_i;
        e_rd0 = m_perr ? 32'hDEAD_BEEF : sram_d_rdata_i;
        e_er0 = m_perr;
      end else begin
        e_rv1 = m_perr ? 1'b1 : sram_d_rvalid_i;
        e_rd1 = m_perr ? 32'hDEAD_BEEF : sram_d_rdata_i;
        e_er1 = m_perr;
      end
    end
  endtask

  task automatic model_commit();
    if (rst_i) begin
      m_last = 1; m_pend = 0; m_eaddr = 0; m_ecnt = 0; hs_prev = 0;
    end else begin
      hs_prev = e_sreq && sram_d_gnt_i;
      m_pend  = e_taken;
      if (e_taken) begin
        m_owner = e_w;
        m_perr  = !e_leg;
        m_last  = e_w;
      end
      if (e_ill) begin
        m_eaddr = e_addr;
        if (m_ecnt < 255) m_ecnt++;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  // Clock edge, then the SRAM model answers exactly one cycle after a handshake.
  task automatic clock_edge();
    @(posedge clk_i);
    model_commit();
    @(negedge clk_i);
    sram_d_rvalid_i = hs_prev;
    sram_d_rdata_i  = $urandom;
  endtask

  task automatic idle_masters();
    m0_req_i = 0; m1_req_i = 0;
  endtask

  task automatic do_reset();
    idle_masters();
    rst_i = 1;
    settle();
    clock_edge();
    rst_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1;
    m0_req_i = 1; m0_addr_i = 32'h8000_0000;
    m1_req_i = 1; m1_addr_i = 32'h8000_0004;
    sram_d_gnt_i = 1; sram_d_rvalid_i = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({m0_gnt_o, m1_gnt_o, sram_d_req_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o} !== 7'b0) begin
        errors++;
        $display("FAIL reset_outputs got %b required 0000000",
                 {m0_gnt_o, m1_gnt_o, sram_d_req_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o});
      end
      clock_edge();
    end
    rst_i = 0;
    idle_masters();
    settle();
    checks++;
    if (err_cnt_o !== 8'd0 || err_addr_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_err_regs got cnt=%0d addr=%h required 0/0", err_cnt_o, err_addr_o);
    end
    checks++;
    if (sram_d_addr_o !== 0 || sram_d_we_o !== 0 || sram_d_be_o !== 0 || sram_d_wdata_o !== 0) begin
      errors++;
      $display("FAIL idle_fields_zero got addr=%h we=%b be=%h wdata=%h required all 0",
               sram_d_addr_o, sram_d_we_o, sram_d_be_o, sram_d_wdata_o);
    end
    clock_edge();
  endtask

  task automatic test_single_read();
    m0_req_i = 1; m0_addr_i = 32'h8000_0010; m0_we_i = 0; m0_be_i = 4'hF;
    sram_d_gnt_i = 1;
    settle();
    checks++;
    if (sram_d_req_o !== 1 || sram_d_addr_o !== 32'h8000_0010 || m0_gnt_o !== 1 || m1_gnt_o !== 0) begin
      errors++;
      $display("FAIL single_read_req got req=%b addr=%h g0=%b g1=%b required 1 80000010 1 0",
               sram_d_req_o, sram_d_addr_o, m0_gnt_o, m1_gnt_o);
    end
    clock_edge();
    m0_req_i = 0;
    settle();
    checks++;
    if (m0_rvalid_o !== 1 || m0_rdata_o !== sram_d_rdata_i || m1_rvalid_o !== 0 || m0_err_o !== 0) begin
      errors++;
      $display("FAIL single_read_resp got rv0=%b rd0=%h rv1=%b err0=%b required 1 %h 0 0",
               m0_rvalid_o, m0_rdata_o, m1_rvalid_o, m0_err_o, sram_d_rdata_i);
    end
    clock_edge();
  endtask

  task automatic test_alternate();
    int prev;
    do_reset();
    prev = -1;
    m0_req_i = 1; m0_addr_i = 32'h8000_0100; m0_we_i = 0;
    m1_req_i = 1; m1_addr_i = 32'h8000_0200; m1_we_i = 1; m1_wdata_i = $urandom;
    sram_d_gnt_i = 1;
    for (int i = 0; i < 6; i++) begin
      settle();
      checks++;
      if (m0_gnt_o !== (i % 2 == 0) || m1_gnt_o !== (i % 2 == 1) ||
          sram_d_addr_o !== ((i % 2 == 0) ? m0_addr_i : m1_addr_i)) begin
        errors++;
        $display("FAIL alternate_grant[%0d] got g0=%b g1=%b addr=%h required winner m%0d", i,
                 m0_gnt_o, m1_gnt_o, sram_d_addr_o, i % 2);
      end
      if (prev >= 0) begin
        checks++;
        if (m0_rvalid_o !== (prev == 0) || m1_rvalid_o !== (prev == 1) ||
            ((prev == 0) ? m0_rdata_o : m1_rdata_o) !== sram_d_rdata_i) begin
          errors++;
          $display("FAIL alternate_resp[%0d] got rv0=%b rv1=%b required owner m%0d", i,
                   m0_rvalid_o, m1_rvalid_o, prev);
        end
      end
      prev = i % 2;
      clock_edge();
      if (prev == 0) m0_addr_i = m0_addr_i + 4;
      else           m1_addr_i = m1_addr_i + 4;
    end
    idle_masters();
    clock_edge();
  endtask

  task automatic test_illegal_end();
    do_reset();
    m1_req_i = 1; m1_addr_i = 32'h8000_C000; m1_we_i = 1; m1_be_i = 4'hF; m1_wdata_i = 32'h1234_5678;
    sram_d_gnt_i = 0;
    settle();
    checks++;
    if (sram_d_req_o !== 0 || m1_gnt_o !== 1 || m0_gnt_o !== 0 || illegal_access_o !== 1) begin
      errors++;
      $display("FAIL illegal_end_grant got req=%b g1=%b g0=%b ill=%b required 0 1 0 1",
               sram_d_req_o, m1_gnt_o, m0_gnt_o, illegal_access_o);
    end
    clock_edge();
    m1_req_i = 0;
    settle();
    checks++;
    if (m1_rvalid_o !== 1 || m1_err_o !== 1 || m1_rdata_o !== 32'hDEAD_BEEF || m0_rvalid_o !== 0 ||
        illegal_access_o !== 0) begin
      errors++;
      $display("FAIL illegal_end_resp got rv1=%b err1=%b rd1=%h rv0=%b ill=%b required 1 1 deadbeef 0 0",
               m1_rvalid_o, m1_err_o, m1_rdata_o, m0_rvalid_o, illegal_access_o);
    end
    checks++;
    if (err_addr_o !== 32'h8000_C000 || err_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL illegal_end_log got addr=%h cnt=%0d required 8000c000 1", err_addr_o, err_cnt_o);
    end
    clock_edge();
  endtask

  task automatic test_boundaries();
    logic [31:0] addrs [6];
    bit          legal [6];
    addrs = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_C004, 32'h8000_0000, 32'h8000_BFFC, 32'h8000_BFFF};
    legal = '{0, 0, 0, 1, 1, 0};
    sram_d_gnt_i = 1;
    for (int i = 0; i < 6; i++) begin
      m0_req_i = 1; m0_addr_i = addrs[i];
      settle();
      checks++;
      if (illegal_access_o !== !legal[i] || sram_d_req_o !== legal[i] || m0_gnt_o !== 1) begin
        errors++;
        $display("FAIL boundary[%h] got ill=%b req=%b g0=%b required ill=%b req=%b g0=1",
                 addrs[i], illegal_access_o, sram_d_req_o, m0_gnt_o, !legal[i], legal[i]);
      end
      clock_edge();
    end
    idle_masters();
    clock_edge();
  endtask

  task automatic test_saturate();
    do_reset();
    sram_d_gnt_i = 0;
    m0_req_i = 1;
    for (int i = 0; i < 300; i++) begin
      m0_addr_i = 32'(i * 4);
      settle();
      clock_edge();
      if (i == 253) begin
        settle();
        checks++;
        if (err_cnt_o !== 8'd254) begin
          errors++;
          $display("FAIL saturate_254 got %0d required 254", err_cnt_o);
        end
      end
    end
    m0_req_i = 0;
    settle();
    checks++;
    if (err_cnt_o !== 8'hFF || err_addr_o !== 32'(299 * 4)) begin
      errors++;
      $display("FAIL saturate_ff got cnt=%h addr=%h required ff %h", err_cnt_o, err_addr_o, 32'(299 * 4));
    end
    clock_edge();
  endtask

  task automatic test_reset_drop();
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'h8000_0040; m0_we_i = 0;
    sram_d_gnt_i = 1;
    settle();
    checks++;
    if (m0_gnt_o !== 1) begin
      errors++;
      $display("FAIL reset_drop_grant got %b required 1", m0_gnt_o);
    end
    clock_edge();
    rst_i = 1;
    m0_req_i = 0;
    settle();
    checks++;
    if (m0_rvalid_o !== 0 || m1_rvalid_o !== 0) begin
      errors++;
      $display("FAIL reset_drop_rvalid got rv0=%b rv1=%b required 0 0", m0_rvalid_o, m1_rvalid_o);
    end
    clock_edge();
    rst_i = 0;
    m0_req_i = 1; m1_req_i = 1; m1_addr_i = 32'h8000_0080;
    settle();
    checks++;
    if (m0_gnt_o !== 1 || m1_gnt_o !== 0 || m0_rvalid_o !== 0 || err_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_drop_tie got g0=%b g1=%b rv0=%b cnt=%0d required 1 0 0 0",
               m0_gnt_o, m1_gnt_o, m0_rvalid_o, err_cnt_o);
    end
    clock_edge();
    idle_masters();
    settle();
    clock_edge();
  endtask

  task automatic test_spurious();
    idle_masters();
    settle();
    clock_edge();
    sram_d_rvalid_i = 1;
    sram_d_rdata_i  = 32'hA5A5_5A5A;
    settle();
    checks++;
    if (m0_rvalid_o !== 0 || m1_rvalid_o !== 0 || m0_rdata_o !== 0 || m1_rdata_o !== 0) begin
      errors++;
      $display("FAIL spurious_rvalid got rv0=%b rv1=%b rd0=%h rd1=%h required 0 0 0 0",
               m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o);
    end
    clock_edge();
  endtask

  task automatic test_random();
    bit g0, g1;
    do_reset();
    g0 = 0; g1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!m0_req_i || g0) begin
        m0_req_i = $urandom_range(0, 9) < 6;
        m0_addr_i = rand_addr(); m0_we_i = 1'($urandom); m0_be_i = 4'($urandom); m0_wdata_i = $urandom;
      end
      if (!m1_req_i || g1) begin
        m1_req_i = $urandom_range(0, 9) < 6;
        m1_addr_i = rand_addr(); m1_we_i = 1'($urandom); m1_be_i = 4'($urandom); m1_wdata_i = $urandom;
      end
      sram_d_gnt_i = $urandom_range(0, 3) != 0;
      rst_i = $urandom_range(0, 299) == 0;
      settle();
      checks++;
      if ({m0_gnt_o, m1_gnt_o, sram_d_req_o} !== {e_gnt0, e_gnt1, e_sreq} ||
          (!rst_i && illegal_access_o !== e_ill)) begin
        errors++;
        $display("FAIL rand_grant[%0d] got g0g1req=%b ill=%b required %b ill=%b", i,
                 {m0_gnt_o, m1_gnt_o, sram_d_req_o}, illegal_access_o, {e_gnt0, e_gnt1, e_sreq}, e_ill);
      end
      if (e_sreq) begin
        checks++;
        if ({sram_d_addr_o, sram_d_we_o, sram_d_be_o, sram_d_wdata_o} !== {e_addr, e_we, e_be, e_wdata}) begin
          errors++;
          $display("FAIL rand_fields[%0d] got %h/%b/%h/%h required %h/%b/%h/%h", i, sram_d_addr_o,
                   sram_d_we_o, sram_d_be_o, sram_d_wdata_o, e_addr, e_we, e_be, e_wdata);
        end
      end
      checks++;
      if ({m0_rvalid_o, m0_err_o, m1_rvalid_o, m1_err_o} !== {e_rv0, e_er0, e_rv1, e_er1} ||
          m0_rdata_o !== e_rd0 || m1_rdata_o !== e_rd1) begin
        errors++;
        $display("FAIL rand_resp[%0d] got rv0 err0 rv1 err1=%b rd0=%h rd1=%h required %b %h %h", i,
                 {m0_rvalid_o, m0_err_o, m1_rvalid_o, m1_err_o}, m0_rdata_o, m1_rdata_o,
                 {e_rv0, e_er0, e_rv1, e_er1}, e_rd0, e_rd1);
      end
      checks++;
      if (err_addr_o !== m_eaddr || err_cnt_o !== 8'(m_ecnt)) begin
        errors++;
        $display("FAIL rand_errlog[%0d] got addr=%h cnt=%0d required %h %0d", i,
                 err_addr_o, err_cnt_o, m_eaddr, m_ecnt);
      end
      g0 = e_gnt0;
      g1 = e_gnt1;
      clock_edge();
    end
    rst_i = 0;
    idle_masters();
    clock_edge();
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_single_read();
    test_alternate();
    test_illegal_end();
    test_boundaries();
    test_saturate();
    test_reset_drop();
    test_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
